// File: rtl/div_radix2_pkg.sv
// div_radix2_pkg: divider FSM states and handshake constants shared by the divider slice.
package div_radix2_pkg;
  typedef enum logic [1:0] {DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END} div_state_t;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START = 1'b1;
endpackage

// File: rtl/div_radix2_if.sv
// div_radix2_if: ALU-to-divider start/ready handshake, operands and {remainder, quotient} result.
interface div_radix2_if #(parameter int WIDTH = 32);
  logic signed_div;
  logic start;
  logic annul;
  logic ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2*WIDTH-1:0] result;
  modport master(output signed_div, a, b, start, annul, input result, ready);
  modport slave(input signed_div, a, b, start, annul, output result, ready);
endinterface

// File: rtl/div_radix2_sign_fix.sv
// div_sign_fix: operand magnitudes going into the divider and sign restoration of quotient/remainder.
module div_sign_fix #(parameter int WIDTH = 32) (
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             q_neg,
  input  logic             r_neg,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] abs_a,
  output logic [WIDTH-1:0] abs_b,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out
);
  always_comb begin
    abs_a = (signed_div && a[WIDTH-1]) ? -a : a;
    abs_b = (signed_div && b[WIDTH-1]) ? -b : b;
    q_out = q_neg ? -q : q;
    r_out = r_neg ? -r : r;
  end
endmodule

// File: rtl/div_radix2.sv
// div_radix2: iterative radix-2 restoring divider, one quotient bit per cycle, registered result.
// DIV_ZERO_FAST_EN: divide-by-zero skips the iterations and completes in two cycles.
module div_radix2 import div_radix2_pkg::*; #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  div_radix2_if.slave d
);
  div_state_t state;
  logic [5:0] cnt;
  logic [2*WIDTH:0] pr;
  logic [WIDTH-1:0] dvs;
  logic q_neg, r_neg, zf;
  logic [WIDTH+1:0] diff;
  logic [2*WIDTH:0] nxt;
  logic [WIDTH-1:0] abs_a, abs_b, q_in, r_in, q_fix, r_fix;
  // pr = {remainder, dividend bits not yet consumed / quotient bits produced}
  always_comb begin
    diff = pr[2*WIDTH:WIDTH-1] - {2'b0, dvs};
    nxt = diff[WIDTH+1] ? {pr[2*WIDTH-1:0], 1'b0} : {diff[WIDTH:0], pr[WIDTH-2:0], 1'b1};
    q_in = (state == DIV_ON) ? nxt[WIDTH-1:0] : pr[WIDTH-1:0];
    r_in = (state == DIV_ON) ? nxt[2*WIDTH-1:WIDTH] : pr[2*WIDTH-1:WIDTH];
`ifdef DIV_ZERO_FAST_EN
    zf = d.b == '0;
`else
    zf = 1'b0;
`endif
  end
  div_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .signed_div(d.signed_div), .a(d.a), .b(d.b), .q_neg(q_neg), .r_neg(r_neg),
    .q(q_in), .r(r_in), .abs_a(abs_a), .abs_b(abs_b), .q_out(q_fix), .r_out(r_fix)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= DIV_FREE;
      cnt <= '0;
      pr <= '0;
      dvs <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      d.ready <= DIV_RESULT_NOT_READY;
      d.result <= '0;
    end else begin
      d.ready <= DIV_RESULT_NOT_READY;
      case (state)
        DIV_FREE: if (d.start == DIV_START && !d.annul) begin
          dvs <= abs_b;
          q_neg <= d.signed_div && (d.a[WIDTH-1] ^ d.b[WIDTH-1]);
          r_neg <= d.signed_div && d.a[WIDTH-1];
          cnt <= '0;
          pr <= zf ? {1'b0, abs_a, {WIDTH{1'b1}}} : {{(WIDTH+1){1'b0}}, abs_a};
          state <= zf ? DIV_BY_ZERO : DIV_ON;
        end
        DIV_BY_ZERO: begin
          state <= d.annul ? DIV_FREE : DIV_END;
          d.ready <= d.annul ? DIV_RESULT_NOT_READY : DIV_RESULT_READY;
          if (!d.annul) d.result <= {r_fix, q_fix};
        end
        DIV_ON: if (d.annul) state <= DIV_FREE;
        else begin
          pr <= nxt;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(WIDTH-1)) begin
            state <= DIV_END;
            d.ready <= DIV_RESULT_READY;
            d.result <= {r_fix, q_fix};
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_radix2.sv
// tb_div_radix2: randomized and directed checks of div_radix2 against an arithmetic reference model.
module tb_div_radix2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  div_radix2_if #(.WIDTH(32)) d();
  div_radix2 #(.WIDTH(32)) dut(.clk(clk), .rst(rst), .d(d));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) begin
      q = (sd && a[31]) ? 32'd1 : 32'hFFFFFFFF;
      r = a;
    end else if (!sd) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      q = a;
      r = 0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
    return {r, q};
  endfunction

  function automatic int lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == 0) ? 2 : 33;
`else
    return 33;
`endif
  endfunction

  task automatic go(input logic sd, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n = 0;
    logic [63:0] exp = ref_div(sd, a, b);
    d.signed_div = sd;
    d.a = a;
    d.b = b;
    d.start = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!d.ready && n < 100);
    d.start = 1'b0;
    check({tag, " latency"}, 64'(n), 64'(lat(b)));
    check({tag, " result"}, d.result, exp);
    @(posedge clk); #1;
    check({tag, " pulse"}, 64'(d.ready), 64'd0);
  endtask

  task automatic watch_idle(input int cyc, input logic [63:0] prev, input string tag);
    int seen = 0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk); #1;
      if (d.ready) seen++;
    end
    check({tag, " no ready"}, 64'(seen), 64'd0);
    check({tag, " result kept"}, d.result, prev);
  endtask

  initial begin
    logic [63:0] prev;
    logic [31:0] ra, rb;
    logic rs;
    d.signed_div = 1'b0;
    d.a = '0;
    d.b = '0;
    d.start = 1'b0;
    d.annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 64'(d.ready), 64'd0);
    check("reset result", d.result, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    go(1'b0, 32'd7, 32'd2, "u7/2");
    check("u7/2 const", d.result, 64'h00000001_00000003);
    go(1'b1, 32'hFFFFFFF9, 32'd2, "s-7/2");
    check("s-7/2 const", d.result, 64'hFFFFFFFF_FFFFFFFD);
    go(1'b1, 32'h80000000, 32'hFFFFFFFF, "s_ovf");
    check("s_ovf const", d.result, 64'h00000000_80000000);
    go(1'b0, 32'h12345678, 32'd0, "u_div0");
    check("u_div0 const", d.result, 64'h12345678_FFFFFFFF);
    go(1'b1, 32'hFFFFFF00, 32'd0, "s_div0_neg");
    go(1'b1, 32'd1234, 32'hFFFFFFF9, "s_pos_neg");
    // start together with annul in the idle state must be ignored
    prev = d.result;
    d.a = 32'd50; d.b = 32'd5; d.signed_div = 1'b0;
    d.start = 1'b1; d.annul = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    d.start = 1'b0; d.annul = 1'b0;
    watch_idle(40, prev, "annul_idle");
    // annul during the iterations
    d.a = 32'd1000; d.b = 32'd3; d.start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    d.annul = 1'b1; d.start = 1'b0;
    @(posedge clk); #1;
    d.annul = 1'b0;
    watch_idle(40, prev, "annul_on");
    go(1'b0, 32'd1000, 32'd3, "after_annul");
    // reset in the middle of an operation
    d.a = 32'd999; d.b = 32'd4; d.start = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b0; d.start = 1'b0;
    @(posedge clk); #1;
    check("midrst ready", 64'(d.ready), 64'd0);
    check("midrst result", d.result, 64'd0);
    rst = 1'b1;
    go(1'b0, 32'd100, 32'd7, "u100/7");
    check("u100/7 const", d.result, 64'h00000002_0000000E);
    go(1'b0, 32'hDEADBEEF, 32'h1234, "b2b");
    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        default: rb = $urandom;
      endcase
      go(rs, ra, rb, "rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
